// File: rtl/intdiv_sched_if.sv
// Request/response bundle between the functional units and the shared divider scheduler.
// The master side drives requests and response acceptance; the slave side is the scheduler.
interface intdiv_sched_if #(
    parameter int N    = 5,
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_z;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, rsp_err, busy
    );
endinterface

// File: rtl/intdiv_sched.sv
// Round-robin scheduler sharing one multicycle signed divider array among NREQ requesters.
// Optional macro INTDIV_DIVZERO_CHECK_EN: divide-by-zero short-circuits to an error response.

// Combinational signed divider: quotient truncates toward zero, computed on magnitudes.
module intdiv_intdiv #(
    parameter int N = 5
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N-1:0] z_o
);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] ax_s;
    logic [N-1:0] ay_s;
    logic [N-1:0] q_s;
    logic [N:0]   rem_s;
    logic         neg_s;

    // Restoring division on operand magnitudes, sign reapplied at the end
    always_comb begin
        ax_s  = x_i[N-1] ? (~x_i + ONE_N) : x_i;
        ay_s  = y_i[N-1] ? (~y_i + ONE_N) : y_i;
        rem_s = {(N+1){1'b0}};
        q_s   = {N{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            rem_s = {rem_s[N-1:0], ax_s[i]};
            if (rem_s >= {1'b0, ay_s}) begin
                rem_s  = rem_s - {1'b0, ay_s};
                q_s[i] = 1'b1;
            end else begin
                q_s[i] = 1'b0;
            end
        end
        neg_s = x_i[N-1] ^ y_i[N-1];
        z_o   = neg_s ? (~q_s + ONE_N) : q_s;
    end
endmodule

module intdiv_sched #(
    parameter int N          = 5,
    parameter int NREQ       = 2,
    parameter int SETTLE_CYC = 2,
    parameter int IDW        = 1
) (
    input  logic          clk,
    input  logic          rst,
    intdiv_sched_if.slave bus
);
    localparam int             CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE_CYC - 1);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   opx_q, opx_d;
    logic [N-1:0]   opy_q, opy_d;
    logic [IDW-1:0] tag_q, tag_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_z_q, rsp_z_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_err_q, rsp_err_d;

    logic            found_s;
    logic [IDW-1:0]  grant_s;
    logic [N-1:0]    sel_x_s;
    logic [N-1:0]    sel_y_s;
    logic [NREQ-1:0] req_ready_s;
    logic [N-1:0]    arr_z_s;

    // Round-robin search: first valid requester strictly after the last grant
    always_comb begin : grant_search
        int idx;
        found_s = 1'b0;
        grant_s = {IDW{1'b0}};
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found_s && bus.req_valid[idx]) begin
                found_s = 1'b1;
                grant_s = IDW'(idx);
            end else begin
            end
        end
    end

    // Operand mux for the granted requester and the one-hot ready vector
    always_comb begin
        sel_x_s     = {N{1'b0}};
        sel_y_s     = {N{1'b0}};
        req_ready_s = {NREQ{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (grant_s == IDW'(k)) begin
                sel_x_s = bus.req_x[k*N +: N];
                sel_y_s = bus.req_y[k*N +: N];
            end else begin
            end
            req_ready_s[k] = (state_q == ST_IDLE) && !rst && found_s && (grant_s == IDW'(k));
        end
    end

    // The array only ever sees registered operands, giving it SETTLE_CYC cycles to resolve
    intdiv_intdiv #(
        .N (N)
    ) u_array (
        .x_i (opx_q),
        .y_i (opy_q),
        .z_o (arr_z_s)
    );

    // Next-state and response register logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    opx_d = sel_x_s;
                    opy_d = sel_y_s;
                    tag_d = grant_s;
                    ptr_d = grant_s;
                    cnt_d = CNT_INIT;
`ifdef INTDIV_DIVZERO_CHECK_EN
                    if (sel_y_s == {N{1'b0}}) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_z_d     = {N{1'b1}};
                        rsp_id_d    = grant_s;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
`else
                    state_d = ST_SETTLE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_z_d     = arr_z_s;
                    rsp_id_d    = tag_q;
                    rsp_err_d   = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset discarding any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_INIT;
            cnt_q       <= {CW{1'b0}};
            opx_q       <= {N{1'b0}};
            opy_q       <= {N{1'b0}};
            tag_q       <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= {N{1'b0}};
            rsp_id_q    <= {IDW{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_intdiv_sched.sv
// Self-checking bench for intdiv_sched: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_intdiv_sched;
    localparam int N          = 5;
    localparam int NREQ       = 2;
    localparam int SETTLE_CYC = 2;
    localparam int IDW        = 1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    intdiv_sched_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    intdiv_sched #(
        .N          (N),
        .NREQ       (NREQ),
        .SETTLE_CYC (SETTLE_CYC),
        .IDW        (IDW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] div_model(input logic [N-1:0] x, input logic [N-1:0] y);
        int xi, yi, q;
        xi = int'($signed(x));
        yi = int'($signed(y));
        q  = xi / yi;
        return q[N-1:0];
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int d = 1; d <= NREQ; d++) begin
            if (v[(last + d) % NREQ]) return (last + d) % NREQ;
        end
        return -1;
    endfunction

    int             m_wait;
    bit             m_rv;
    logic [N-1:0]   m_z;
    logic [IDW-1:0] m_id;
    bit             m_err;
    bit             m_zk;
    int             m_last;
    logic [N-1:0]   p_z;
    logic [IDW-1:0] p_id;
    bit             p_zk;
    bit             chk_en;

    function automatic bit m_busy();
        return (m_wait > 0) || m_rv;
    endfunction

    // Transaction-level model: an operation is pending for SETTLE_CYC edges, then held until taken
    always @(posedge clk) begin : model
        int g;
        logic [N-1:0] gx, gy;
        if (rst) begin
            m_wait <= 0; m_rv <= 1'b0; m_z <= '0; m_id <= '0; m_err <= 1'b0;
            m_zk <= 1'b1; m_last <= NREQ - 1; chk_en <= 1'b1;
        end else if (m_rv) begin
            if (bus.rsp_ready) m_rv <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_rv <= 1'b1; m_z <= p_z; m_id <= p_id; m_err <= 1'b0; m_zk <= p_zk;
            end
        end else begin
            g = rr_pick(bus.req_valid, m_last);
            if (g >= 0) begin
                gx = bus.req_x[g*N +: N];
                gy = bus.req_y[g*N +: N];
                m_last <= g;
`ifdef INTDIV_DIVZERO_CHECK_EN
                if (gy == '0) begin
                    m_rv <= 1'b1; m_z <= '1; m_err <= 1'b1; m_id <= IDW'(g); m_zk <= 1'b1;
                end else begin
                    m_wait <= SETTLE_CYC; p_z <= div_model(gx, gy); p_id <= IDW'(g); p_zk <= 1'b1;
                end
`else
                m_wait <= SETTLE_CYC;
                p_id   <= IDW'(g);
                p_zk   <= (gy != '0);
                p_z    <= (gy != '0) ? div_model(gx, gy) : '0;
`endif
            end
        end
    end

    // Compare process: every cycle, well after inputs change and away from the active edge
    always @(negedge clk) begin : compare
        logic [NREQ-1:0] exp_rdy;
        int g;
        #3;
        if (chk_en) begin
            exp_rdy = '0;
            if (!rst && !m_busy()) begin
                g = rr_pick(bus.req_valid, m_last);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("cmp_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("cmp_busy", 32'(bus.busy), 32'(m_busy()));
            chk("cmp_rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
            chk("cmp_rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("cmp_rsp_err", 32'(bus.rsp_err), 32'(m_err));
            if (m_zk) chk("cmp_rsp_z", 32'(bus.rsp_z), 32'(m_z));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int k, input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
        bus.req_valid[k]     = v;
        bus.req_x[k*N +: N]  = x;
        bus.req_y[k*N +: N]  = y;
    endtask

    task automatic wait_grant(output int idx, output int at);
        int n;
        n   = 0;
        idx = -1;
        #1;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        at = cyc;
        if (bus.req_ready == '0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_timeout: got no req_ready after %0d cycles, required a grant", n);
        end else begin
            for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) idx = k;
        end
    endtask

    // lat counts sampling points from the grant cycle to the first one showing rsp_valid
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk); #1; lat++;
        end while (!bus.rsp_valid && lat < 20);
        if (!bus.rsp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: got rsp_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    int idx, t1, t2, lat, c0;

    initial begin
        rst = 1'b1;
        n_tests = 0; n_fail = 0; cyc = 0; chk_en = 1'b0;
        m_wait = 0; m_rv = 1'b0; m_zk = 1'b0; m_last = NREQ - 1;
        bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.rsp_ready = 1'b0;

        // pin the model against hand-computed values
        chk("pin_div_7_3", 32'(div_model(5'b00111, 5'b00011)), 32'(5'b00010));
        chk("pin_div_m7_2", 32'(div_model(5'b11001, 5'b00010)), 32'(5'b11101));
        chk("pin_div_ovf", 32'(div_model(5'b10000, 5'b11111)), 32'(5'b10000));
        chk("pin_rr_after1", 32'(rr_pick(2'b11, 1)), 32'd0);
        chk("pin_rr_after0", 32'(rr_pick(2'b11, 0)), 32'd1);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_z", 32'(bus.rsp_z), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single op from requester 0
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 5'b00111, 5'b00011);
        wait_grant(idx, t1);
        chk("single_req_ready", 32'(bus.req_ready), 32'(2'b01));
        wait_rsp(lat);
        chk("single_latency", 32'(lat), 32'(SETTLE_CYC + 1));
        chk("single_z", 32'(bus.rsp_z), 32'(5'b00010));
        chk("single_id", 32'(bus.rsp_id), 32'd0);
        chk("single_err", 32'(bus.rsp_err), 32'd0);
        set_req(0, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // back-to-back from requester 1; operands change right after the accept edge
        set_req(1, 1'b1, 5'b00111, 5'b00010);
        wait_grant(idx, t1);
        chk("b2b_grant1", 32'(idx), 32'd1);
        @(negedge clk);
        set_req(1, 1'b1, 5'b01000, 5'b00010);
        wait_rsp(lat);
        chk("b2b_latency", 32'(lat), 32'(SETTLE_CYC));
        chk("b2b_z1", 32'(bus.rsp_z), 32'(5'b00011));
        chk("b2b_id1", 32'(bus.rsp_id), 32'd1);
        wait_grant(idx, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'(SETTLE_CYC + 2));
        wait_rsp(lat);
        chk("b2b_z2", 32'(bus.rsp_z), 32'(5'b00100));
        chk("b2b_id2", 32'(bus.rsp_id), 32'd1);
        set_req(1, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // contention: both requesters valid continuously
        set_req(0, 1'b1, 5'b00111, 5'b00011);
        set_req(1, 1'b1, 5'b01000, 5'b00010);
        for (int i = 0; i < 4; i++) begin
            wait_grant(idx, t1);
            chk("cont_grant", 32'(idx), 32'(i % 2));
            wait_rsp(lat);
            chk("cont_rsp_id", 32'(bus.rsp_id), 32'(i % 2));
            chk("cont_rsp_z", 32'(bus.rsp_z), (i % 2 == 0) ? 32'(5'b00010) : 32'(5'b00100));
        end
        set_req(0, 1'b0, 5'b00000, 5'b00000);
        set_req(1, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // backpressure: response held five cycles, no grant until handshake
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 5'b01001, 5'b00011);
        wait_grant(idx, t1);
        chk("bp_grant0", 32'(idx), 32'd0);
        set_req(1, 1'b1, 5'b00101, 5'b00001);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
            chk("bp_z_held", 32'(bus.rsp_z), 32'(5'b00011));
            chk("bp_id_held", 32'(bus.rsp_id), 32'd0);
            chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        c0 = cyc;
        wait_grant(idx, t2);
        chk("bp_grant1", 32'(idx), 32'd1);
        chk("bp_grant_after_hs", 32'(t2 - c0), 32'd1);
        wait_rsp(lat);
        chk("bp_z_req1", 32'(bus.rsp_z), 32'(5'b00101));
        set_req(0, 1'b0, 5'b00000, 5'b00000);
        set_req(1, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // reset during SETTLE discards the operation and the rr pointer
        set_req(0, 1'b1, 5'b00111, 5'b00001);
        wait_grant(idx, t1);
        chk("rst_pre_grant", 32'(idx), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 5'b00000, 5'b00000);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        set_req(0, 1'b1, 5'b00111, 5'b00001);
        set_req(1, 1'b1, 5'b00110, 5'b00011);
        wait_grant(idx, t1);
        chk("rst_ptr_grant0", 32'(idx), 32'd0);
        wait_rsp(lat);
        chk("rst_post_z", 32'(bus.rsp_z), 32'(5'b00111));
        set_req(0, 1'b0, 5'b00000, 5'b00000);
        set_req(1, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // divide by zero from requester 1
        set_req(1, 1'b1, 5'b00111, 5'b00000);
        wait_grant(idx, t1);
        chk("dz_grant", 32'(idx), 32'd1);
        wait_rsp(lat);
`ifdef INTDIV_DIVZERO_CHECK_EN
        chk("dz_latency", 32'(lat), 32'd1);
        chk("dz_z", 32'(bus.rsp_z), 32'(5'b11111));
        chk("dz_err", 32'(bus.rsp_err), 32'd1);
`else
        chk("dz_latency", 32'(lat), 32'(SETTLE_CYC + 1));
        chk("dz_err", 32'(bus.rsp_err), 32'd0);
`endif
        chk("dz_id", 32'(bus.rsp_id), 32'd1);
        set_req(1, 1'b0, 5'b00000, 5'b00000);
        @(negedge clk);

        // random traffic, checked cycle by cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NREQ; k++) begin
                set_req(k, 1'($urandom_range(0, 1)), N'($urandom), N'($urandom));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
